// File: rtl/lc3_mem_pkg.sv
// Shared types and limits for the LC3 multi-channel memory front end.
package lc3_mem_pkg;

  localparam int unsigned LC3_AW  = 16;
  localparam int unsigned LC3_DW  = 16;
  localparam int unsigned MAX_NCH = 8;
  localparam int unsigned MAX_LAT = 15;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lc3_mem_arb_if.sv
// Requester-side handshake plus memory-side bus of the LC3 memory arbiter.
interface lc3_mem_arb_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 16,
  parameter int unsigned DW  = 16
);
  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [NCH-1:0]    ack;
  logic [DW-1:0]     rdata;
  logic [GW-1:0]     gnt_idx;
  logic              busy;

  logic [AW-1:0]     mar;
  logic [DW-1:0]     mdr;
  logic              memwe;
  logic [DW-1:0]     memOut;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, gnt_idx, busy
  );

  modport slave (
    input  req, we, addr, wdata, memOut,
    output ack, rdata, gnt_idx, busy, mar, mdr, memwe
  );

  modport mem (
    input  mar, mdr, memwe,
    output memOut
  );

endinterface

// File: rtl/lc3_mem_arb_rr_arb.sv
// Combinational round-robin picker: first asserted request above last_gnt, with wrap.
module lc3_rr_arb
  import lc3_mem_pkg::*;
#(
  parameter int unsigned NCH = 2
) (
  input  logic [NCH-1:0]          req,
  input  logic [idx_w(NCH)-1:0]   last_gnt,
  output logic [idx_w(NCH)-1:0]   gnt_idx,
  output logic                    any
);

  localparam int unsigned GW = idx_w(NCH);

  logic [GW-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    // Offset NCH lands back on last_gnt, so it only wins when it is the sole requester.
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = GW'((32'(last_gnt) + i) % NCH);
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_arb.sv
// LC3 unified-memory front end: round-robin arbitration of NCH requesters onto one
// single-port memory with request/ack handshake and configurable read latency.
module lc3_mem_arb
  import lc3_mem_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = LC3_AW,
  parameter int unsigned DW  = LC3_DW,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  lc3_mem_arb_if.slave  bus
);

  localparam int unsigned GW = idx_w(NCH);

  if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
    $error("lc3_mem_arb: NCH=%0d outside 1..%0d", NCH, MAX_NCH);
  end
  if (LAT < 1 || LAT > MAX_LAT) begin : g_bad_lat
    $error("lc3_mem_arb: LAT=%0d outside 1..%0d", LAT, MAX_LAT);
  end

  arb_state_e       state_q, state_d;
  logic [AW-1:0]    mar_q, mar_d;
  logic [DW-1:0]    mdr_q, mdr_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             we_q, we_d;
  logic             memwe_q, memwe_d;
  logic [GW-1:0]    gnt_q, gnt_d;
  logic [GW-1:0]    last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [GW-1:0]    pick;
  logic             any;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;
  logic             sel_we;

  lc3_rr_arb #(.NCH(NCH)) u_rr (
    .req      (bus.req),
    .last_gnt (last_q),
    .gnt_idx  (pick),
    .any      (any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pick == GW'(i)) begin
        sel_addr  = bus.addr[i*AW +: AW];
        sel_wdata = bus.wdata[i*DW +: DW];
        sel_we    = bus.we[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      memwe_q <= 1'b0;
      gnt_q   <= '0;
      last_q  <= GW'(NCH - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      memwe_q <= memwe_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = ACCESS;
      ACCESS:  if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: everything is latched at the grant edge; memwe is set there so it
  // is high for exactly the first ACCESS cycle.
  always_comb begin
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    memwe_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          mar_d   = sel_addr;
          mdr_d   = sel_wdata;
          we_d    = sel_we;
          memwe_d = sel_we;
          gnt_d   = pick;
          last_d  = pick;
          cnt_d   = sel_we ? CNT_W'(1) : CNT_W'(LAT);
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1) && !we_q) rdata_d = bus.memOut;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.ack = '0;
    if (state_q == DONE) bus.ack[gnt_q] = 1'b1;
    bus.busy    = (state_q != IDLE);
    bus.rdata   = rdata_q;
    bus.gnt_idx = gnt_q;
    bus.mar     = mar_q;
    bus.mdr     = mdr_q;
    bus.memwe   = memwe_q;
  end

endmodule

// File: tb/tb_lc3_mem_arb.sv
// Bench for lc3_mem_arb: two configurations (2ch/LAT1, 4ch/LAT3) checked each cycle
// against a transaction-timestamp model, plus directed literal scenarios.
module tb_lc3_mem_arb;

  localparam int NI   = 2;
  localparam int MAXC = 4;

  int nch [NI] = '{2, 4};
  int lat [NI] = '{1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst     [NI];
  logic [MAXC-1:0]  req     [NI];
  logic [MAXC-1:0]  we      [NI];
  logic [15:0]      addr    [NI][MAXC];
  logic [15:0]      wdata   [NI][MAXC];
  logic [MAXC-1:0]  ack     [NI];
  logic [15:0]      rdata   [NI];
  logic [15:0]      mar     [NI];
  logic [15:0]      mdr     [NI];
  logic [15:0]      mem_out [NI];
  logic [1:0]       gnt     [NI];
  logic             busy    [NI];
  logic             memwe   [NI];

  logic [15:0] dmem [NI][65536];
  logic [15:0] mmem [NI][65536];

  int checks   = 0;
  int failures = 0;

  lc3_mem_arb_if #(.NCH(2), .AW(16), .DW(16)) bus_a ();
  lc3_mem_arb_if #(.NCH(4), .AW(16), .DW(16)) bus_b ();

  assign bus_a.req    = req[0][1:0];
  assign bus_a.we     = we[0][1:0];
  assign bus_a.addr   = {addr[0][1], addr[0][0]};
  assign bus_a.wdata  = {wdata[0][1], wdata[0][0]};
  assign bus_a.memOut = mem_out[0];
  assign ack[0]   = {2'b00, bus_a.ack};
  assign rdata[0] = bus_a.rdata;
  assign gnt[0]   = {1'b0, bus_a.gnt_idx};
  assign busy[0]  = bus_a.busy;
  assign mar[0]   = bus_a.mar;
  assign mdr[0]   = bus_a.mdr;
  assign memwe[0] = bus_a.memwe;

  assign bus_b.req    = req[1];
  assign bus_b.we     = we[1];
  assign bus_b.addr   = {addr[1][3], addr[1][2], addr[1][1], addr[1][0]};
  assign bus_b.wdata  = {wdata[1][3], wdata[1][2], wdata[1][1], wdata[1][0]};
  assign bus_b.memOut = mem_out[1];
  assign ack[1]   = bus_b.ack;
  assign rdata[1] = bus_b.rdata;
  assign gnt[1]   = bus_b.gnt_idx;
  assign busy[1]  = bus_b.busy;
  assign mar[1]   = bus_b.mar;
  assign mdr[1]   = bus_b.mdr;
  assign memwe[1] = bus_b.memwe;

  lc3_mem_arb #(.NCH(2), .AW(16), .DW(16), .LAT(1)) u_dut_a (
    .clk(clk), .reset(rst[0]), .bus(bus_a)
  );
  lc3_mem_arb #(.NCH(4), .AW(16), .DW(16), .LAT(3)) u_dut_b (
    .clk(clk), .reset(rst[1]), .bus(bus_b)
  );

  // Environment memory: address held stable on mar, so a combinational read is valid by the capture edge.
  assign mem_out[0] = dmem[0][mar[0]];
  assign mem_out[1] = dmem[1][mar[1]];
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++)
      if (memwe[k] === 1'b1) dmem[k][mar[k]] <= mdr[k];
  end

  // Reference model: each transaction is reduced to its grant cycle and ack cycle.
  int          cyc = 0;
  bit          mvalid [NI];
  int          g_cyc  [NI];
  int          a_cyc  [NI];
  int          m_last [NI];
  int          m_gnt  [NI];
  bit          m_we   [NI];
  logic [15:0] m_mar  [NI];
  logic [15:0] m_mdr  [NI];
  logic [15:0] m_rd   [NI];
  logic [15:0] m_rbase[NI];

  function automatic logic [15:0] exp_rdata(input int k, input int t);
    if (a_cyc[k] >= 0 && !m_we[k] && t >= a_cyc[k]) return m_rd[k];
    return m_rbase[k];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst[k] === 1'b1) begin
        mvalid[k] = 1'b1;
        g_cyc[k] = -1; a_cyc[k] = -1;
        m_last[k] = nch[k] - 1; m_gnt[k] = 0; m_we[k] = 1'b0;
        m_mar[k] = '0; m_mdr[k] = '0; m_rd[k] = '0; m_rbase[k] = '0;
      end else if (mvalid[k] && cyc > a_cyc[k] && req[k] != '0) begin
        int w;
        w = -1;
        for (int i = 1; i <= nch[k]; i++) begin
          int c;
          c = (m_last[k] + i) % nch[k];
          if (w < 0 && req[k][c]) w = c;
        end
        m_rbase[k] = exp_rdata(k, cyc);
        m_we[k]  = we[k][w];
        m_mar[k] = addr[k][w];
        m_mdr[k] = wdata[k][w];
        m_gnt[k] = w;
        m_last[k] = w;
        g_cyc[k] = cyc + 1;
        a_cyc[k] = cyc + 1 + (m_we[k] ? 1 : lat[k]);
        if (m_we[k]) mmem[k][m_mar[k]] = m_mdr[k];
        else         m_rd[k] = mmem[k][m_mar[k]];
      end
    end
    cyc = cyc + 1;
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s inst%0d cyc=%0d actual=0x%0h required=0x%0h", name, k, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (mvalid[k]) begin
        logic [3:0] e_ack;
        e_ack = (cyc == a_cyc[k]) ? 4'(1 << m_gnt[k]) : 4'b0;
        check("ack",   k, 32'(ack[k]),   32'(e_ack));
        check("busy",  k, 32'(busy[k]),  32'(g_cyc[k] >= 0 && cyc >= g_cyc[k] && cyc <= a_cyc[k]));
        check("memwe", k, 32'(memwe[k]), 32'(cyc == g_cyc[k] && m_we[k]));
        check("gnt",   k, 32'(gnt[k]),   32'(m_gnt[k]));
        check("mar",   k, 32'(mar[k]),   32'(m_mar[k]));
        check("mdr",   k, 32'(mdr[k]),   32'(m_mdr[k]));
        check("rdata", k, 32'(rdata[k]), 32'(exp_rdata(k, cyc)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int k, input int ch);
    we[k][ch]    = 1'($urandom_range(0, 1));
    addr[k][ch]  = 16'h0100 + 16'($urandom_range(0, 15));
    wdata[k][ch] = 16'($urandom);
    req[k][ch]   = 1'b1;
  endtask

  task automatic txn(input int k, input int ch, input bit w, input logic [15:0] a, input logic [15:0] d,
                     output int lat_o, output logic [15:0] rd_o);
    bit got;
    int rise;
    tick();
    we[k][ch] = w; addr[k][ch] = a; wdata[k][ch] = d; req[k][ch] = 1'b1;
    rise = cyc; got = 1'b0; lat_o = -1; rd_o = '0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (ack[k][ch] === 1'b1) begin
        got = 1'b1; lat_o = cyc - rise; rd_o = rdata[k];
      end
    end
    tick();
    req[k][ch] = 1'b0;
  endtask

  initial begin
    int          lt;
    logic [15:0] rd;
    int          nack;
    logic [3:0]  a;
    int          ordq[$];
    logic [15:0] rdq[$];
    int          exp5 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [3:0]  seen [NI];
    int          rnd_acks [NI];

    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req[k] = '0; we[k] = '0; rnd_acks[k] = 0;
      for (int c = 0; c < MAXC; c++) begin addr[k][c] = '0; wdata[k][c] = '0; end
      for (int x = 0; x < 65536; x++) begin
        dmem[k][x] = 16'(x) ^ 16'hC3A5;
        mmem[k][x] = 16'(x) ^ 16'hC3A5;
      end
    end
    dmem[1][16'h0010] = 16'hBEEF;
    mmem[1][16'h0010] = 16'hBEEF;
    repeat (3) tick();
    rst[0] = 1'b0; rst[1] = 1'b0;

    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_busy",  k, 32'(busy[k]),  32'd0);
      check("rst_ack",   k, 32'(ack[k]),   32'd0);
      check("rst_memwe", k, 32'(memwe[k]), 32'd0);
      check("rst_mar",   k, 32'(mar[k]),   32'd0);
      check("rst_rdata", k, 32'(rdata[k]), 32'd0);
    end

    txn(0, 0, 1'b1, 16'h3000, 16'h1234, lt, rd);
    check("t1_latency", 0, 32'(lt), 32'd2);
    check("t1_memory",  0, 32'(dmem[0][16'h3000]), 32'h1234);
    txn(0, 0, 1'b0, 16'h3000, 16'h0000, lt, rd);
    check("t2_latency", 0, 32'(lt), 32'd2);
    check("t2_rdata",   0, 32'(rd), 32'h1234);

    // 4 channels streaming: the fresh pointer must give a strict 0..3 rotation.
    tick();
    for (int c = 0; c < 4; c++) new_req(1, c);
    nack = 0;
    for (int n = 0; n < 200 && nack < 8; n++) begin
      @(negedge clk);
      a = ack[1];
      if (a != '0) begin
        check("t5_onehot", 1, 32'($onehot(a)), 32'd1);
        ordq.push_back(int'(gnt[1]));
        nack++;
      end
      tick();
      if (a != '0) begin
        if (nack == 8) req[1] = '0;
        else for (int c = 0; c < 4; c++) if (a[c]) new_req(1, c);
      end
    end
    check("t5_acks", 1, 32'(nack), 32'd8);
    for (int i = 0; i < 8; i++)
      check("t5_order", 1, 32'((i < ordq.size()) ? ordq[i] : -1), 32'(exp5[i]));

    txn(1, 1, 1'b0, 16'h0010, 16'h0000, lt, rd);
    check("t3_latency", 1, 32'(lt), 32'd4);
    check("t3_rdata",   1, 32'(rd), 32'hBEEF);

    tick(); rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    tick();
    we[0][0] = 1'b1; addr[0][0] = 16'h0001; wdata[0][0] = 16'hAAAA;
    we[0][1] = 1'b0; addr[0][1] = 16'h0001; wdata[0][1] = 16'h0000;
    req[0] = 4'b0011;
    ordq.delete();
    nack = 0;
    for (int n = 0; n < 60 && nack < 2; n++) begin
      @(negedge clk);
      a = ack[0];
      if (a != '0) begin
        ordq.push_back(int'(gnt[0]));
        rdq.push_back(rdata[0]);
        nack++;
      end
      tick();
      req[0] = req[0] & ~a;
    end
    check("t4_acks",   0, 32'(nack), 32'd2);
    check("t4_first",  0, 32'((ordq.size() > 0) ? ordq[0] : -1), 32'd0);
    check("t4_second", 0, 32'((ordq.size() > 1) ? ordq[1] : -1), 32'd1);
    check("t4_rdata",  0, 32'((rdq.size() > 1) ? rdq[1] : 16'h0000), 32'hAAAA);
    req[0] = '0;

    tick();
    we[1][0] = 1'b0; addr[1][0] = 16'h0020; req[1][0] = 1'b1;
    tick();
    tick();
    rst[1] = 1'b1; req[1][0] = 1'b0;
    tick();
    rst[1] = 1'b0;
    check("t6_busy",  1, 32'(busy[1]),  32'd0);
    check("t6_memwe", 1, 32'(memwe[1]), 32'd0);
    check("t6_mar",   1, 32'(mar[1]),   32'd0);
    check("t6_mdr",   1, 32'(mdr[1]),   32'd0);
    check("t6_rdata", 1, 32'(rdata[1]), 32'd0);
    nack = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack[1] != '0) nack++;
    end
    check("t6_no_ack", 1, 32'(nack), 32'd0);
    txn(1, 0, 1'b0, 16'h0020, 16'h0000, lt, rd);
    check("t6_latency", 1, 32'(lt), 32'd4);
    check("t6_rdata2",  1, 32'(rd), 32'hC385);

    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) seen[k] = ack[k];
      tick();
      for (int k = 0; k < NI; k++) begin
        rnd_acks[k] += $countones(seen[k]);
        if (rst[k]) begin
          rst[k] = 1'b0;
        end else if ($urandom_range(0, 399) == 0) begin
          rst[k] = 1'b1;
          req[k] = '0;
        end else begin
          for (int c = 0; c < nch[k]; c++) begin
            if (seen[k][c]) begin
              if ($urandom_range(0, 1) == 0) req[k][c] = 1'b0;
              else new_req(k, c);
            end else if (!req[k][c]) begin
              if ($urandom_range(0, 2) == 0) new_req(k, c);
            end else if (c == m_gnt[k] && cyc >= g_cyc[k] && cyc <= a_cyc[k]) begin
              we[k][c]    = 1'($urandom_range(0, 1));
              addr[k][c]  = 16'($urandom);
              wdata[k][c] = 16'($urandom);
            end
          end
        end
      end
    end
    for (int k = 0; k < NI; k++) begin
      req[k] = '0;
      rst[k] = 1'b0;
    end
    repeat (8) tick();
    for (int k = 0; k < NI; k++)
      check("rnd_progress", k, 32'(rnd_acks[k] >= 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures = failures + 1;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arb.md
Name: lc3_mem_arb

Overview:
Parametrised multi-channel front end for the LC3 unified memory. It arbitrates NCH requesters (core instruction/data ports, testbench DMA) onto one single-port memory using the LC3 memory signal set (mar, mdr, memwe, memOut). It adds a request/ack handshake, round-robin fairness and configurable read latency; the single-master, zero-wait memory path has none of these. It sits between the core/testbench agents and the memory model.

Parameters:
NCH, 2, number of requester channels (1..8)
AW, 16, address width (mar)
DW, 16, data width (mdr/memOut)
LAT, 1, memory read latency in cycles from address driven to memOut valid (1..15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  NCH  per-channel request, level, held until ack
we  input  NCH  per-channel write enable, qualified by req
addr  input  NCH*AW  per-channel address, channel i at [i*AW +: AW]
wdata  input  NCH*DW  per-channel write data, channel i at [i*DW +: DW]
ack  output  NCH  one-hot, one-cycle completion pulse
rdata  output  DW  read data, valid in the ack cycle for reads
gnt_idx  output  $clog2(NCH) or 1  index of channel currently/last served
busy  output  1  high whenever state != IDLE
mar  output  AW  memory address
mdr  output  DW  memory write data
memwe  output  1  memory write strobe
memOut  input  DW  memory read data

Behaviour:
- One clock domain; reset is synchronous and active-high. Every output resets to 0: ack, rdata, gnt_idx, busy, mar, mdr, memwe. The round-robin pointer resets to NCH-1, so channel 0 wins the first contested arbitration.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: req is sampled only in this state. If req != 0, the winner is the first asserted channel searching upward, with wrap, from last_gnt+1. At the clock edge, latch the winner's we/addr/wdata into mar/mdr/an internal we_q, set gnt_idx, update last_gnt, load cnt = (we ? 1 : LAT), and go to ACCESS. If req == 0, stay in IDLE.
- ACCESS: mar/mdr are held stable. memwe = we_q during the first ACCESS cycle only. memwe is registered, so it is asserted in exactly one cycle. cnt decrements each cycle. When cnt == 1:
  - for a read, capture memOut into rdata at that edge;
  - go to DONE.
- ACCESS length is therefore 1 cycle for a write and LAT cycles for a read.
- DONE: ack[gnt_idx] = 1 for exactly one cycle. rdata holds the captured value and stays held until the next read capture. For writes, rdata is unchanged. Next state is IDLE.
- Transaction latency: req rise (in IDLE) to ack is 2 cycles for a write and LAT+1 cycles for a read. Throughput is one access per (ACCESS length + 2) cycles.
- Requester rule: deassert req (or present the next request) at the edge where it sees ack. A req still high in the following IDLE cycle is treated as a new request.
- Fairness: under continuous requests from all channels, grants rotate 0,1,..,NCH-1,0. No channel waits more than NCH-1 transactions.
- Changes to we/addr/wdata on a channel after its grant edge have no effect on the transaction in flight.
- Reset mid-transaction: at the reset edge, go to IDLE. No ack is issued, memwe drops, and mar/mdr/rdata clear.
- NCH == 1: arbitration is degenerate and gnt_idx stays 0; timing is unchanged.
- Out-of-range parameters (NCH > 8, LAT == 0) trigger an elaboration-time $error.

Decomposition:
- Package lc3_mem_pkg: state enum (IDLE, ACCESS, DONE), default LC3_AW/LC3_DW = 16, MAX_NCH = 8, MAX_LAT = 15.
- Sub-module lc3_rr_arb: combinational round-robin picker. Inputs: req[NCH], last_gnt. Outputs: gnt_idx, any. It is instantiated once. The top holds the FSM, counter and datapath registers.

Test Plan:
1. Default NCH=2, LAT=1. Ch0 writes addr 0x3000, data 0x1234 → memwe high for 1 cycle with mar=0x3000, mdr=0x1234; ack[0] 2 cycles after req.
2. Same config: ch0 reads 0x3000 with the memory model returning 0x1234 → ack[0] 2 cycles after req; rdata=0x1234 in the ack cycle.
3. LAT=3: ch1 reads 0x0010 (memOut=0xBEEF) → no memwe; ack[1] 4 cycles after req; rdata=0xBEEF.
4. Both channels request in the same IDLE cycle (ch0 write 0x0001→0xAAAA, ch1 read 0x0001):
   - ch0 is served first;
   - ch1 is served next and reads back 0xAAAA;
   - gnt_idx sequence is 0,1.
5. NCH=4, all channels request continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3; exactly 8 ack pulses, one-hot.
6. LAT=3 read in progress, reset pulsed in the second ACCESS cycle → no ack; busy, memwe, mar and rdata are 0 the cycle after reset. A new ch0 request afterwards completes normally.
